m68k_bus_engine: RTL and testbench

M68K_BUS_ENGINE -- requirements
Module: m68k_bus_engine

---
 rtl/m68k_bus_pkg.sv | 41 ++++
 rtl/m68k_req_fifo.sv | 55 +++++
 rtl/m68k_bus_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_m68k_bus_engine.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types for the 68k bus engine: FSM states, size/status encodings,
// the queued request record and the UDS/LDS strobe rule.
package m68k_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_S1,
      ST_S2,
      ST_S3,
      ST_S4,
      ST_S5,
      ST_S7
   } state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_WORD = 2'd1;
   localparam logic [1:0] SIZE_LONG = 2'd2;

   localparam logic [1:0] STATUS_OK      = 2'd0;
   localparam logic [1:0] STATUS_BERR    = 2'd1;
   localparam logic [1:0] STATUS_TIMEOUT = 2'd2;

   typedef struct packed {
      logic [23:0] addr;
      logic [1:0]  size;
      logic        read;
      logic [2:0]  fc;
      logic [31:0] wdata;
   } req_t;

   localparam int REQ_W = $bits(req_t);

   // Returns {uds, lds}: bytes select one lane by address parity, wider sizes use both.
   function automatic logic [1:0] strobes(input logic [1:0] size, input logic a0);
      if (size == SIZE_BYTE) begin
         return a0 ? 2'b01 : 2'b10;
      end
      return 2'b11;
   endfunction

endpackage

// File: rtl/m68k_req_fifo.sv
// Request queue for the 68k bus engine; head is always visible, push is
// ignored when full and pop is ignored when empty.
module m68k_req_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge sys_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/m68k_bus_engine.sv
// Queued MC68000 bus-cycle sequencer driven by 7 MHz edge strobes.
// Optional S4 timeout is built only when M68K_BUS_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no cycle; pop next request on MC rising edge
// ST_S1   | FC driven, waiting to drive the address bus
// ST_S2   | address driven, waiting to assert AS / R/W (and read strobes)
// ST_S3   | AS asserted, waiting to drive data on writes
// ST_S4   | wait states until DTACK/BERR (or timeout) on a falling edge
// ST_S5   | terminated; capture read data, release AS/UDS/LDS
// ST_S7   | release buses; start second long half or respond
module m68k_bus_engine
   import m68k_bus_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        mc_clk_rising,
   input  logic        mc_clk_falling,
   input  logic        dtack_n_sync,
   input  logic        berr_n_sync,
   input  logic [15:0] din_sync,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [23:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_read,
   input  logic [2:0]  req_fc,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_status,
   output logic [22:0] a_out,
   output logic [15:0] d_out,
   output logic [2:0]  fc_out,
   output logic        abus_oe,
   output logic        dbus_oe,
   output logic        fc_oe,
   output logic        as_oe,
   output logic        rw_oe,
   output logic        uds_oe,
   output logic        lds_oe,
   output logic        busy
);

   req_t        req_in;
   req_t        head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;

   state_t      state;
   logic [23:0] cur_addr;
   logic [1:0]  cur_size;
   logic        cur_read;
   logic [15:0] wdata_lo;
   logic        second;
   logic [1:0]  cyc_status;
   logic [31:0] rdata_acc;
   logic [1:0]  cur_strb;

`ifdef M68K_BUS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_cnt;
`endif

   assign req_in    = '{addr: req_addr, size: req_size, read: req_read, fc: req_fc, wdata: req_wdata};
   assign req_ready = !fifo_full;
   assign pop       = (state == ST_IDLE) && mc_clk_rising && !fifo_empty;
   assign busy      = !fifo_empty || (state != ST_IDLE);
   assign cur_strb  = strobes(cur_size, cur_addr[0]);

   m68k_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REQ_W)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .push      (req_valid),
      .push_data (req_in),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         cur_addr   <= '0;
         cur_size   <= SIZE_BYTE;
         cur_read   <= 1'b0;
         wdata_lo   <= '0;
         second     <= 1'b0;
         cyc_status <= STATUS_OK;
         rdata_acc  <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_status <= STATUS_OK;
         a_out      <= '0;
         d_out      <= '0;
         fc_out     <= '0;
         abus_oe    <= 1'b0;
         dbus_oe    <= 1'b0;
         fc_oe      <= 1'b0;
         as_oe      <= 1'b0;
         rw_oe      <= 1'b0;
         uds_oe     <= 1'b0;
         lds_oe     <= 1'b0;
`ifdef M68K_BUS_TIMEOUT_EN
         tmo_cnt    <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  cur_addr   <= head.addr;
                  cur_size   <= head.size;
                  cur_read   <= head.read;
                  wdata_lo   <= head.wdata[15:0];
                  second     <= 1'b0;
                  cyc_status <= STATUS_OK;
                  rdata_acc  <= '0;
                  fc_out     <= head.fc;
                  fc_oe      <= 1'b1;
                  a_out      <= head.addr[23:1];
                  // Byte writes replicate the byte on both lanes, as the 68000 does.
                  if (head.size == SIZE_LONG)
                     d_out <= head.wdata[31:16];
                  else if (head.size == SIZE_BYTE)
                     d_out <= {head.wdata[7:0], head.wdata[7:0]};
                  else
                     d_out <= head.wdata[15:0];
                  state <= ST_S1;
               end
            end
            ST_S1: begin
               if (mc_clk_falling) begin
                  abus_oe <= 1'b1;
                  state   <= ST_S2;
               end
            end
            ST_S2: begin
               if (mc_clk_rising) begin
                  as_oe <= 1'b1;
                  rw_oe <= !cur_read;
                  if (cur_read) begin
                     uds_oe <= cur_strb[1];
                     lds_oe <= cur_strb[0];
                  end
                  state <= ST_S3;
               end
            end
            ST_S3: begin
               if (mc_clk_falling) begin
                  dbus_oe <= !cur_read;
`ifdef M68K_BUS_TIMEOUT_EN
                  tmo_cnt <= TMO_LOAD;
`endif
                  state   <= ST_S4;
               end
            end
            ST_S4: begin
               if (mc_clk_rising && !cur_read) begin
                  uds_oe <= cur_strb[1];
                  lds_oe <= cur_strb[0];
               end
               if (mc_clk_falling) begin
                  if (!berr_n_sync) begin
                     cyc_status <= STATUS_BERR;
                     state      <= ST_S5;
                  end else if (!dtack_n_sync) begin
                     state <= ST_S5;
                  end
`ifdef M68K_BUS_TIMEOUT_EN
                  else if (tmo_cnt == TW'(1)) begin
                     cyc_status <= STATUS_TIMEOUT;
                     state      <= ST_S5;
                  end else begin
                     tmo_cnt <= tmo_cnt - 1'b1;
                  end
`endif
               end
            end
            ST_S5: begin
               if (mc_clk_falling) begin
                  if (cur_read && (cyc_status == STATUS_OK)) begin
                     if (cur_size == SIZE_LONG) begin
                        if (second) rdata_acc[15:0]  <= din_sync;
                        else        rdata_acc[31:16] <= din_sync;
                     end else if (cur_size == SIZE_BYTE) begin
                        rdata_acc <= {24'h0, cur_addr[0] ? din_sync[7:0] : din_sync[15:8]};
                     end else begin
                        rdata_acc <= {16'h0, din_sync};
                     end
                  end
                  as_oe  <= 1'b0;
                  uds_oe <= 1'b0;
                  lds_oe <= 1'b0;
                  state  <= ST_S7;
               end
            end
            ST_S7: begin
               if (mc_clk_rising) begin
                  abus_oe <= 1'b0;
                  dbus_oe <= 1'b0;
                  if ((cur_size == SIZE_LONG) && !second && (cyc_status == STATUS_OK)) begin
                     second <= 1'b1;
                     a_out  <= cur_addr[23:1] + 23'd1;
                     d_out  <= wdata_lo;
                     state  <= ST_S1;
                  end else begin
                     fc_oe      <= 1'b0;
                     rw_oe      <= 1'b0;
                     rsp_valid  <= 1'b1;
                     rsp_status <= cyc_status;
                     rsp_rdata  <= (cyc_status == STATUS_OK) ? rdata_acc : 32'h0;
                     state      <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_m68k_bus_engine.sv
// Directed bench for m68k_bus_engine: vector table plus hand-written FIFO,
// reset and (with M68K_BUS_TIMEOUT_EN) timeout sequences.
module tb_m68k_bus_engine;

   logic        sys_clk;
   logic        sys_rst;
   logic        mc_clk_rising;
   logic        mc_clk_falling;
   logic        dtack_n_sync;
   logic        berr_n_sync;
   logic [15:0] din_sync;
   logic        req_valid;
   logic        req_ready;
   logic [23:0] req_addr;
   logic [1:0]  req_size;
   logic        req_read;
   logic [2:0]  req_fc;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic [22:0] a_out;
   logic [15:0] d_out;
   logic [2:0]  fc_out;
   logic        abus_oe, dbus_oe, fc_oe, as_oe, rw_oe, uds_oe, lds_oe;
   logic        busy;

   m68k_bus_engine #(
      .FIFO_DEPTH     (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .mc_clk_rising  (mc_clk_rising),
      .mc_clk_falling (mc_clk_falling),
      .dtack_n_sync   (dtack_n_sync),
      .berr_n_sync    (berr_n_sync),
      .din_sync       (din_sync),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_addr       (req_addr),
      .req_size       (req_size),
      .req_read       (req_read),
      .req_fc         (req_fc),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_status     (rsp_status),
      .a_out          (a_out),
      .d_out          (d_out),
      .fc_out         (fc_out),
      .abus_oe        (abus_oe),
      .dbus_oe        (dbus_oe),
      .fc_oe          (fc_oe),
      .as_oe          (as_oe),
      .rw_oe          (rw_oe),
      .uds_oe         (uds_oe),
      .lds_oe         (lds_oe),
      .busy           (busy)
   );

   int n_checks = 0;
   int n_err    = 0;

   logic        mc_en;
   int          mc_phase;

   int          as_cnt;
   int          rsp_cnt;
   int          fall_cnt;
   int          fall_at_rsp;
   logic        prev_as;
   logic        uds_seen, lds_seen;
   logic [22:0] a_cap [4];
   logic [15:0] d_cap [4];
   logic [2:0]  fc_cap;
   logic        rw_cap;
   logic [33:0] rsp_q [$];

   typedef struct {
      logic [23:0] addr;
      logic [1:0]  size;
      logic        rd;
      logic [31:0] wd;
      logic        berr;
      logic [31:0] rdata;
      logic [1:0]  status;
      int          as_n;
      logic        uds;
      logic        lds;
      logic [22:0] a0;
      logic [22:0] a1;
      logic [15:0] d0;
      logic [15:0] d1;
   } vec_t;

   vec_t vecs [10];

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // MC clock strobes (period 4 sys_clk) and a bus model returning din = address word.
   initial begin
      mc_phase       = 0;
      mc_clk_rising  = 1'b0;
      mc_clk_falling = 1'b0;
      din_sync       = '0;
      forever begin
         @(posedge sys_clk);
         #1;
         if (mc_en) begin
            mc_clk_rising  = (mc_phase == 0);
            mc_clk_falling = (mc_phase == 2);
            mc_phase       = (mc_phase + 1) % 4;
         end else begin
            mc_clk_rising  = 1'b0;
            mc_clk_falling = 1'b0;
         end
         din_sync = a_out[15:0];
      end
   end

   initial begin
      prev_as = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (as_oe && !prev_as) begin
            if (as_cnt < 4) begin
               a_cap[as_cnt] = a_out;
               d_cap[as_cnt] = d_out;
            end
            fc_cap   = fc_out;
            rw_cap   = rw_oe;
            fall_cnt = 0;
            as_cnt++;
         end
         prev_as = as_oe;
         if (as_oe) begin
            uds_seen = uds_seen | uds_oe;
            lds_seen = lds_seen | lds_oe;
         end
         if (mc_clk_falling) fall_cnt++;
         if (rsp_valid) begin
            rsp_cnt++;
            fall_at_rsp = fall_cnt;
            rsp_q.push_back({rsp_status, rsp_rdata});
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      as_cnt      = 0;
      rsp_cnt     = 0;
      fall_cnt    = 0;
      fall_at_rsp = 0;
      uds_seen    = 1'b0;
      lds_seen    = 1'b0;
      a_cap[0] = '0; a_cap[1] = '0;
      d_cap[0] = '0; d_cap[1] = '0;
      rsp_q.delete();
   endtask

   task automatic push_req(input logic [23:0] addr, input logic [1:0] size, input logic rd,
                           input logic [2:0] fc, input logic [31:0] wd);
      int k;
      @(negedge sys_clk);
      req_valid = 1'b1;
      req_addr  = addr;
      req_size  = size;
      req_read  = rd;
      req_fc    = fc;
      req_wdata = wd;
      k = 0;
      while (!req_ready && k < 400) begin
         @(negedge sys_clk);
         k++;
      end
      chk("push_ready", {31'h0, req_ready}, 32'h1);
      @(negedge sys_clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n, input string name);
      int k;
      k = 0;
      while (rsp_cnt < n && k < 600) begin
         @(negedge sys_clk);
         k++;
      end
      chk(name, {31'h0, rsp_cnt >= n}, 32'h1);
   endtask

   function automatic logic [31:0] oes();
      return {25'h0, abus_oe, dbus_oe, fc_oe, as_oe, rw_oe, uds_oe, lds_oe};
   endfunction

   initial begin
      vecs[0] = '{24'hDFF01C, 2'd1, 1'b1, 32'h0,        1'b0, 32'h0000F80E, 2'd0, 1, 1'b1, 1'b1, 23'h6FF80E, 23'h0,      16'h0,    16'h0};
      vecs[1] = '{24'h123456, 2'd0, 1'b1, 32'h0,        1'b0, 32'h0000001A, 2'd0, 1, 1'b1, 1'b0, 23'h091A2B, 23'h0,      16'h0,    16'h0};
      vecs[2] = '{24'h123457, 2'd0, 1'b1, 32'h0,        1'b0, 32'h0000002B, 2'd0, 1, 1'b0, 1'b1, 23'h091A2B, 23'h0,      16'h0,    16'h0};
      vecs[3] = '{24'h000400, 2'd2, 1'b1, 32'h0,        1'b0, 32'h02000201, 2'd0, 2, 1'b1, 1'b1, 23'h000200, 23'h000201, 16'h0,    16'h0};
      vecs[4] = '{24'hFFFFFE, 2'd2, 1'b0, 32'h12345678, 1'b0, 32'h0,        2'd0, 2, 1'b1, 1'b1, 23'h7FFFFF, 23'h000000, 16'h1234, 16'h5678};
      vecs[5] = '{24'h001000, 2'd1, 1'b0, 32'h0000BEEF, 1'b0, 32'h0,        2'd0, 1, 1'b1, 1'b1, 23'h000800, 23'h0,      16'hBEEF, 16'h0};
      vecs[6] = '{24'h000011, 2'd0, 1'b0, 32'h00000077, 1'b0, 32'h0,        2'd0, 1, 1'b0, 1'b1, 23'h000008, 23'h0,      16'h7777, 16'h0};
      vecs[7] = '{24'h000400, 2'd2, 1'b1, 32'h0,        1'b1, 32'h0,        2'd1, 1, 1'b1, 1'b1, 23'h000200, 23'h0,      16'h0,    16'h0};
      vecs[8] = '{24'h002000, 2'd1, 1'b1, 32'h0,        1'b1, 32'h0,        2'd1, 1, 1'b1, 1'b1, 23'h001000, 23'h0,      16'h0,    16'h0};
      vecs[9] = '{24'hFFFFFE, 2'd2, 1'b1, 32'h0,        1'b0, 32'hFFFF0000, 2'd0, 2, 1'b1, 1'b1, 23'h7FFFFF, 23'h000000, 16'h0,    16'h0};

      sys_rst      = 1'b1;
      mc_en        = 1'b1;
      dtack_n_sync = 1'b0;
      berr_n_sync  = 1'b1;
      req_valid    = 1'b0;
      req_addr     = '0;
      req_size     = '0;
      req_read     = 1'b0;
      req_fc       = '0;
      req_wdata    = '0;
      clear_mon();

      // Reset state
      repeat (4) @(negedge sys_clk);
      chk("rst_oes",       oes(), 32'h0);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_busy",      {31'h0, busy}, 32'h0);
      chk("rst_status",    {30'h0, rsp_status}, 32'h0);
      chk("rst_rdata",     rsp_rdata, 32'h0);
      chk("rst_ready",     {31'h0, req_ready}, 32'h1);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);

      // Vector table
      for (int i = 0; i < 10; i++) begin
         clear_mon();
         berr_n_sync = !vecs[i].berr;
         push_req(vecs[i].addr, vecs[i].size, vecs[i].rd, 3'(i), vecs[i].wd);
         wait_rsp(1, $sformatf("v%0d_rsp_timeout", i));
         repeat (24) @(negedge sys_clk);
         chk($sformatf("v%0d_rsp_cnt", i), rsp_cnt, 1);
         chk($sformatf("v%0d_rdata", i),   rsp_rdata, vecs[i].rdata);
         chk($sformatf("v%0d_status", i),  {30'h0, rsp_status}, {30'h0, vecs[i].status});
         chk($sformatf("v%0d_as_cnt", i),  as_cnt, vecs[i].as_n);
         chk($sformatf("v%0d_uds", i),     {31'h0, uds_seen}, {31'h0, vecs[i].uds});
         chk($sformatf("v%0d_lds", i),     {31'h0, lds_seen}, {31'h0, vecs[i].lds});
         chk($sformatf("v%0d_a0", i),      {9'h0, a_cap[0]}, {9'h0, vecs[i].a0});
         chk($sformatf("v%0d_fc", i),      {29'h0, fc_cap}, 32'(i % 8));
         chk($sformatf("v%0d_rw", i),      {31'h0, rw_cap}, {31'h0, !vecs[i].rd});
         if (!vecs[i].rd)
            chk($sformatf("v%0d_d0", i), {16'h0, d_cap[0]}, {16'h0, vecs[i].d0});
         if (vecs[i].as_n == 2) begin
            chk($sformatf("v%0d_a1", i), {9'h0, a_cap[1]}, {9'h0, vecs[i].a1});
            if (!vecs[i].rd)
               chk($sformatf("v%0d_d1", i), {16'h0, d_cap[1]}, {16'h0, vecs[i].d1});
         end
         chk($sformatf("v%0d_idle_oes", i), oes(), 32'h0);
         chk($sformatf("v%0d_idle_busy", i), {31'h0, busy}, 32'h0);
      end
      berr_n_sync = 1'b1;

      // FIFO fill with the engine stalled, then drain in order
      clear_mon();
      mc_en = 1'b0;
      for (int k = 1; k <= 4; k++)
         push_req(24'(k * 16), 2'd1, 1'b1, 3'd5, 32'h0);
      @(negedge sys_clk);
      req_valid = 1'b1;
      req_addr  = 24'h000050;
      req_size  = 2'd1;
      req_read  = 1'b1;
      req_fc    = 3'd5;
      @(negedge sys_clk);
      chk("fifo_full_ready", {31'h0, req_ready}, 32'h0);
      chk("fifo_full_busy",  {31'h0, busy}, 32'h1);
      mc_en = 1'b1;
      begin
         int k;
         k = 0;
         while (!req_ready && k < 100) begin
            @(negedge sys_clk);
            k++;
         end
      end
      chk("fifo_fifth_ready", {31'h0, req_ready}, 32'h1);
      @(negedge sys_clk);
      req_valid = 1'b0;
      wait_rsp(5, "fifo_rsp_timeout");
      repeat (24) @(negedge sys_clk);
      chk("fifo_rsp_cnt", rsp_cnt, 5);
      for (int k = 0; k < 5; k++) begin
         if (k < rsp_q.size())
            chk($sformatf("fifo_order%0d", k), rsp_q[k][31:0], 32'((k + 1) * 8));
      end

      // Push and pop on the same cycle keep the queue depth
      clear_mon();
      mc_en = 1'b0;
      push_req(24'h000060, 2'd1, 1'b1, 3'd2, 32'h0);
      @(negedge sys_clk);
      req_valid     = 1'b1;
      req_addr      = 24'h000070;
      mc_clk_rising = 1'b1;
      @(negedge sys_clk);
      req_valid = 1'b0;
      chk("pushpop_busy", {31'h0, busy}, 32'h1);
      mc_en = 1'b1;
      wait_rsp(2, "pushpop_rsp_timeout");
      repeat (60) @(negedge sys_clk);
      chk("pushpop_rsp_cnt", rsp_cnt, 2);
      if (rsp_q.size() >= 2) begin
         chk("pushpop_first",  rsp_q[0][31:0], 32'h30);
         chk("pushpop_second", rsp_q[1][31:0], 32'h38);
      end

`ifdef M68K_BUS_TIMEOUT_EN
      // No DTACK: timeout after 8 S4 falling edges
      clear_mon();
      dtack_n_sync = 1'b1;
      push_req(24'h000200, 2'd1, 1'b1, 3'd1, 32'h0);
      wait_rsp(1, "tmo_rsp_timeout");
      @(negedge sys_clk);
      chk("tmo_status", {30'h0, rsp_status}, 32'h2);
      chk("tmo_rdata",  rsp_rdata, 32'h0);
      chk("tmo_falls",  fall_at_rsp, 10);
      chk("tmo_oes",    oes(), 32'h0);
      dtack_n_sync = 1'b0;
      repeat (4) @(negedge sys_clk);
`endif

      // Reset in S4 of a write releases the bus and drops the request
      clear_mon();
      dtack_n_sync = 1'b1;
      push_req(24'h000300, 2'd1, 1'b0, 3'd3, 32'h0000ABCD);
      begin
         int k;
         k = 0;
         while (!(dbus_oe && uds_oe) && k < 100) begin
            @(negedge sys_clk);
            k++;
         end
      end
      chk("midrst_in_s4", {31'h0, dbus_oe && uds_oe}, 32'h1);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      chk("midrst_oes",  oes(), 32'h0);
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      sys_rst      = 1'b0;
      dtack_n_sync = 1'b0;
      repeat (80) @(negedge sys_clk);
      chk("midrst_no_rsp", rsp_cnt, 0);
      chk("midrst_idle",   {31'h0, busy}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
